// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing helpers and data width.
// Used by the receiver now and intended for the transmit block as well.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ST_W   = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

  // Clocks per bit for a given system clock and baud rate.
  function automatic int unsigned bps_cnt(input int unsigned clk_freq, input int unsigned bps);
    return clk_freq / bps;
  endfunction

  // Bit-counter value at which a bit is sampled (its centre).
  function automatic int unsigned mid_bit(input int unsigned cnt);
    return cnt / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_recv_if.sv
// Receiver-to-bridge result bus: byte, completion/error strobes and busy flag.
interface uart_recv_if;
  import uart_pkg::*;

  logic              uart_done;
  logic [DATA_W-1:0] uart_data;
  logic              frame_err;
  logic              parity_err;
  logic              rx_busy;

  modport master (output uart_done, uart_data, frame_err, parity_err, rx_busy);
  modport slave  (input  uart_done, uart_data, frame_err, parity_err, rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous RX pin into the clock domain and flags its falling edge.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic rxd,
  output logic cur,
  output logic start_flag
);

  logic [2:0] sync;

  // Two synchroniser stages plus one delay stage; reset to the idle-high level.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) sync <= 3'b111;
    else            sync <= {sync[1:0], rxd};
  end

  assign cur        = sync[1];
  assign start_flag = sync[2] & ~sync[1];

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1 LSB first; define UART_RX_PARITY_EN for 8E1 with parity checking.
// Samples each bit at its centre and reports each frame with a one-cycle strobe.
module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned UART_BPS = 128000
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         uart_rxd,
  uart_recv_if.master  rx
);

  localparam int unsigned BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned MID_CNT = mid_bit(BPS_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(MID_CNT);

  logic line, start_flag;

  uart_rx_sync u_sync (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rxd        (uart_rxd),
    .cur        (line),
    .start_flag (start_flag)
  );

  logic [ST_W-1:0]   state, state_nxt;
  logic [CNT_W-1:0]  clk_cnt, cnt_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [DATA_W-1:0] data, data_nxt;
  logic              done, done_nxt;
  logic              ferr, ferr_nxt;
  logic              busy, busy_nxt;
  logic              mid;
`ifdef UART_RX_PARITY_EN
  logic              perr, perr_nxt;
  logic              par_bad, par_bad_nxt;
`endif

  assign mid = (clk_cnt == CNT_MID);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data    <= '0;
      done    <= 1'b0;
      ferr    <= 1'b0;
      busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr    <= 1'b0;
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      clk_cnt <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
      data    <= data_nxt;
      done    <= done_nxt;
      ferr    <= ferr_nxt;
      busy    <= busy_nxt;
`ifdef UART_RX_PARITY_EN
      perr    <= perr_nxt;
      par_bad <= par_bad_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (clk_cnt == CNT_MAX) ? '0 : clk_cnt + CNT_W'(1);
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = data;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt    = 1'b0;
    par_bad_nxt = par_bad;
`endif

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start_flag) begin
          state_nxt = ST_START;
          busy_nxt  = 1'b1;
        end
      end
      // A start bit that is high again at its centre was a glitch.
      ST_START: begin
        if (mid) begin
          if (!line) begin
            state_nxt = ST_DATA;
            bit_nxt   = '0;
          end else begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (mid) begin
          shift_nxt[bit_cnt] = line;
          bit_nxt            = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      // Even parity: the parity bit equals the XOR of the data bits.
      ST_PARITY: begin
        if (mid) begin
          par_bad_nxt = line ^ (^shift);
          state_nxt   = ST_STOP;
        end
      end
`endif
      // Leave at the stop-bit centre so a following start edge is not missed.
      ST_STOP: begin
        if (mid) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          if (!line) begin
            ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            perr_nxt = 1'b1;
`endif
          end else begin
            data_nxt = shift;
            done_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign rx.uart_done = done;
  assign rx.uart_data = data;
  assign rx.frame_err = ferr;
  assign rx.rx_busy   = busy;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err = perr;
`else
  assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: directed frames plus random frames scored against a queue-based
// frame model; honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_recv;

  localparam int unsigned CLK_FREQ = 3_200_000;
  localparam int unsigned UART_BPS = 100_000;
  localparam int unsigned BPS      = CLK_FREQ / UART_BPS;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR      = 1'b1;
  localparam int unsigned NBITS    = 11;
`else
  localparam bit          PAR      = 1'b0;
  localparam int unsigned NBITS    = 10;
`endif
  // Strobe arrives half a bit into the stop bit, plus synchroniser/register delay.
  localparam int unsigned LAT_MIN  = (NBITS - 1) * BPS + BPS / 2;
  localparam int unsigned LAT_MAX  = LAT_MIN + 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic uart_rxd  = 1'b1;

  uart_recv_if u_if ();

  uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .rx        (u_if)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          kind;   // 0 done, 1 frame error, 2 parity error
    logic [7:0]  data;   // uart_data expected after the strobe
    int unsigned t0;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  last_good = 8'h00;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge sys_clk) cyc++;

  // Strobe scoreboard.
  bit          prev_strobe = 1'b0;
  int          n_strobe;
  int          kind_seen;
  int unsigned lat;
  ev_t         ev;
  always @(negedge sys_clk) begin
    n_strobe = int'(u_if.uart_done) + int'(u_if.frame_err) + int'(u_if.parity_err);
    if (prev_strobe) check_val("strobe_width", n_strobe, 0);
    if (n_strobe != 0) begin
      check_val("strobe_onehot", n_strobe, 1);
      check_val("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        kind_seen = u_if.uart_done ? 0 : (u_if.frame_err ? 1 : 2);
        check_val("strobe_kind", kind_seen, ev.kind);
        check_val("uart_data", u_if.uart_data, ev.data);
        lat = cyc - ev.t0;
        check_val("latency_window", (lat >= LAT_MIN) && (lat <= LAT_MAX), 1);
      end
    end
    prev_strobe = (n_strobe != 0);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rxd = b;
    wait_clk(BPS);
  endtask

  // Predicts the outcome from the frame rules, then drives the frame.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok);
    ev_t  e;
    logic p;
    p = (^d) ^ ~par_ok;
    e.t0 = cyc;
    if (!stop) begin
      e.kind = 1; e.data = last_good;
    end else if (PAR && !par_ok) begin
      e.kind = 2; e.data = last_good;
    end else begin
      e.kind = 0; e.data = d; last_good = d;
    end
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR) drive_bit(p);
    drive_bit(stop);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < int'(2 * NBITS * BPS)) begin
      wait_clk(1);
      k++;
    end
    check_val(tag, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_done"}, u_if.uart_done, 0);
    check_val({tag, "_data"}, u_if.uart_data, 0);
    check_val({tag, "_ferr"}, u_if.frame_err, 0);
    check_val({tag, "_perr"}, u_if.parity_err, 0);
    check_val({tag, "_busy"}, u_if.rx_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    bit         stop, pok;
    int         gap;

    wait_clk(5);
    check_idle_outputs("reset");
    sys_rst_n = 1'b1;
    wait_clk(2 * BPS);

    // Single frame, busy observed mid-frame.
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        wait_clk(3 * BPS);
        check_val("busy_mid_frame", u_if.rx_busy, 1);
      end
    join
    drain("drain_a5");
    wait_clk(BPS);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    drain("drain_b2b");
    wait_clk(BPS);

    // Short glitch is accepted as a start edge, then rejected at the bit centre.
    uart_rxd = 1'b0;
    wait_clk(BPS / 4);
    uart_rxd = 1'b1;
    check_val("glitch_busy_rise", u_if.rx_busy, 1);
    wait_clk(BPS - BPS / 4);
    check_val("glitch_busy_fall", u_if.rx_busy, 0);
    wait_clk(2 * BPS);

    // Stop bit low: frame error, byte register keeps last good value.
    send_frame(8'h3C, 1'b0, 1'b1);
    uart_rxd = 1'b1;
    wait_clk(2 * BPS);
    drain("drain_ferr");
    check_val("data_hold_after_ferr", u_if.uart_data, last_good);

    // Break: line held low well past one frame gives a single frame error.
    send_frame(8'h00, 1'b0, 1'b1);
    wait_clk(3 * BPS);
    check_val("break_idle", u_if.rx_busy, 0);
    uart_rxd = 1'b1;
    wait_clk(2 * BPS);
    drain("drain_break");

    // Reset during bit 4 of a frame aborts it without a strobe.
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    uart_rxd = d[4];
    wait_clk(BPS / 2);
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    wait_clk(4);
    check_idle_outputs("midreset");
    sys_rst_n = 1'b1;
    last_good = 8'h00;
    wait_clk(2 * BPS);
    check_val("post_reset_busy", u_if.rx_busy, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    drain("drain_5a");
    wait_clk(BPS);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clk(BPS);
    send_frame(8'h07, 1'b1, 1'b0);
    drain("drain_parity");
    wait_clk(BPS);
`endif

    // Random frames, errors and gaps.
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      pok  = PAR ? ($urandom_range(0, 3) != 0) : 1'b1;
      send_frame(d, stop, pok);
      gap = int'($urandom_range(0, 3)) * int'($urandom_range(0, BPS));
      if (!stop && gap < int'(BPS)) gap = int'(BPS);
      uart_rxd = 1'b1;
      if (gap > 0) wait_clk(gap);
    end
    drain("drain_random");
    check_val("final_data", u_if.uart_data, last_good);
    check_val("final_busy", u_if.rx_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
